cmp_latch_array: RTL



---
 rtl/cmp_latch_array.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cmp_latch_array.sv
// rtl/cmp_latch_array.sv - multi-channel clocked decision latch with sync, glitch filter, strobe mode and event counters
//
// Each channel resolves a differential pair (vip, vin) into a held decision.
// The decision follows vip while the pair disagrees and holds while it agrees.
// A programmable filter requires filt_len consecutive qualifying mismatching
// cycles before the decision flips.
//
// Ports:
//   clk       single clock, all state on the rising edge
//   rst       synchronous reset, active-high
//   en        global enable; 0 freezes filter, outputs and counters
//   vip, vin  [CH] differential inputs, asynchronous to clk
//   filt_len  [FILT_W] qualifying cycles needed to flip; 0 acts as 1
//   mode      0 = continuous, 1 = strobed
//   strobe    sample qualifier, used only when mode=1
//   cnt_clr   synchronous clear of all event counters
//   cmp_out   [CH] held decision per channel
//   edge_evt  [CH] one-cycle pulse when the matching cmp_out bit changes
//   evt_cnt   [CH*CNT_W] saturating event counters, channel i at [i*CNT_W +: CNT_W]

module cmp_latch_array #(
    parameter int CH     = 4,
    parameter int FILT_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH-1:0]       vip,
    input  logic [CH-1:0]       vin,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic                mode,
    input  logic                strobe,
    input  logic                cnt_clr,
    output logic [CH-1:0]       cmp_out,
    output logic [CH-1:0]       edge_evt,
    output logic [CH*CNT_W-1:0] evt_cnt
);

    // Two-flop synchronisers, free-running regardless of en/mode
    logic [CH-1:0] vip_m_q, vip_s_q;
    logic [CH-1:0] vin_m_q, vin_s_q;

    logic [FILT_W-1:0] flt_q [CH];
    logic [FILT_W-1:0] flt_d [CH];
    logic [CNT_W-1:0]  cnt_q [CH];
    logic [CNT_W-1:0]  cnt_d [CH];
    logic [CH-1:0]     out_q, out_d;
    logic [CH-1:0]     evt_q, evt_d;

    logic              qual;
    logic [FILT_W:0]   thresh;

    // One bit wider than the filter counter so the incremented count never
    // wraps before it is compared against the threshold.
    assign thresh = (filt_len == '0) ? (FILT_W+1)'(1) : {1'b0, filt_len};
    assign qual   = en & (~mode | strobe);

    always_comb begin
        out_d = out_q;
        evt_d = '0;
        for (int i = 0; i < CH; i++) begin
            flt_d[i] = flt_q[i];
            cnt_d[i] = cnt_q[i];
            if (qual) begin
                if ((vip_s_q[i] ^ vin_s_q[i]) && (vip_s_q[i] != out_q[i])) begin
                    // >= rather than == so a filt_len lowered below the
                    // running count flips on the next mismatching cycle
                    if (({1'b0, flt_q[i]} + 1'b1) >= thresh) begin
                        out_d[i] = vip_s_q[i];
                        evt_d[i] = 1'b1;
                        flt_d[i] = '0;
                    end else begin
                        flt_d[i] = flt_q[i] + 1'b1;
                    end
                end else begin
                    flt_d[i] = '0;
                end
            end
            // Clear wins over the old count, but a coincident event still lands
            if (cnt_clr) begin
                cnt_d[i] = evt_d[i] ? CNT_W'(1) : '0;
            end else if (evt_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vip_m_q <= '0;
            vip_s_q <= '0;
            vin_m_q <= '0;
            vin_s_q <= '0;
            out_q   <= '0;
            evt_q   <= '0;
            for (int i = 0; i < CH; i++) begin
                flt_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            vip_m_q <= vip;
            vip_s_q <= vip_m_q;
            vin_m_q <= vin;
            vin_s_q <= vin_m_q;
            out_q   <= out_d;
            evt_q   <= evt_d;
            for (int i = 0; i < CH; i++) begin
                flt_q[i] <= flt_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cmp_out  = out_q;
    assign edge_evt = evt_q;

    for (genvar g = 0; g < CH; g++) begin : g_cnt
        assign evt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule
